// File: rtl/ysyx_idu_pkg.sv
// Shared encodings and the decoded micro-op bundle for the IDU stage.
package ysyx_idu_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [31:0] InstEcall  = 32'h0000_0073;
    localparam logic [31:0] InstEbreak = 32'h0010_0073;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;
    localparam logic [6:0] Funct7Mul  = 7'b0000001;

    typedef enum logic [3:0] {
        AluAdd   = 4'b0000,
        AluSll   = 4'b0001,
        AluSlt   = 4'b0010,
        AluSltu  = 4'b0011,
        AluXor   = 4'b0100,
        AluSrl   = 4'b0101,
        AluOr    = 4'b0110,
        AluAnd   = 4'b0111,
        AluSub   = 4'b1000,
        AluSra   = 4'b1101,
        AluPassB = 4'b1110
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        BrNone = 3'b000,
        BrEq   = 3'b010,
        BrNe   = 3'b011,
        BrLt   = 3'b100,
        BrGe   = 3'b101,
        BrLtu  = 3'b110,
        BrGeu  = 3'b111
    } br_type_e;

    typedef enum logic [1:0] {
        WbNone = 2'b00,
        WbPc4  = 2'b01,
        WbAlu  = 2'b10,
        WbMem  = 2'b11
    } rf_wr_sel_e;

    typedef enum logic [2:0] {
        DmRdNone = 3'b000,
        DmRdLb   = 3'b001,
        DmRdLbu  = 3'b010,
        DmRdLh   = 3'b011,
        DmRdLhu  = 3'b100,
        DmRdLw   = 3'b101
    } dm_rd_sel_e;

    typedef enum logic [1:0] {
        DmWrNone = 2'b00,
        DmWrSb   = 2'b01,
        DmWrSh   = 2'b10,
        DmWrSw   = 2'b11
    } dm_wr_sel_e;

    // Register fields are kept at full RV32I width; the stage trims them for RV32E.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf_wr_en;
        rf_wr_sel_e  rf_wr_sel;
        logic        do_jump;
        br_type_e    br_type;
        logic        alu_a_sel;
        logic        alu_b_sel;
        alu_ctrl_e   alu_ctrl;
        logic [3:0]  mdu_op;
        dm_rd_sel_e  dm_rd_sel;
        dm_wr_sel_e  dm_wr_sel;
        logic        ebreak;
        logic        illegal;
    } idu_bundle_t;

endpackage

// File: rtl/ysyx_idu_if.sv
// IFU->IDU and IDU->EXU handshake signals of the decode stage.
interface ysyx_idu_if #(
    parameter int unsigned RF_ADDR_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [31:0]          in_pc;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_pc;
    logic [31:0]          out_imm;
    logic [RF_ADDR_W-1:0] out_rs1;
    logic [RF_ADDR_W-1:0] out_rs2;
    logic [RF_ADDR_W-1:0] out_rd;
    logic                 out_rf_wr_en;
    logic [1:0]           out_rf_wr_sel;
    logic                 out_do_jump;
    logic [2:0]           out_br_type;
    logic                 out_alu_a_sel;
    logic                 out_alu_b_sel;
    logic [3:0]           out_alu_ctrl;
    logic [3:0]           out_mdu_op;
    logic [2:0]           out_dm_rd_sel;
    logic [1:0]           out_dm_wr_sel;
    logic                 out_ebreak;
    logic                 out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
        input  out_rf_wr_en, out_rf_wr_sel, out_do_jump, out_br_type, out_alu_a_sel,
        input  out_alu_b_sel, out_alu_ctrl, out_mdu_op, out_dm_rd_sel, out_dm_wr_sel,
        input  out_ebreak, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
        output out_rf_wr_en, out_rf_wr_sel, out_do_jump, out_br_type, out_alu_a_sel,
        output out_alu_b_sel, out_alu_ctrl, out_mdu_op, out_dm_rd_sel, out_dm_wr_sel,
        output out_ebreak, out_illegal
    );
endinterface

// File: rtl/ysyx_idu_dec.sv
// Combinational RV32I/E(+M) instruction decoder producing one micro-op bundle.
module ysyx_idu_dec
    import ysyx_idu_pkg::*;
#(
    parameter bit          EN_M      = 1'b0,
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output idu_bundle_t bundle
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    function automatic logic idx_bad(input logic [4:0] r);
        return (r >> RF_ADDR_W) != 5'd0;
    endfunction

    idu_bundle_t dec;
    logic        bad_enc, use_rd, use_rs1, use_rs2, illegal;

    always_comb begin
        dec           = '0;
        dec.pc        = pc;
        dec.rs1       = rs1;
        dec.rs2       = rs2;
        dec.rd        = rd;
        dec.alu_a_sel = 1'b1;
        dec.alu_b_sel = 1'b1;
        dec.alu_ctrl  = AluAdd;
        dec.br_type   = BrNone;
        dec.rf_wr_sel = WbNone;
        dec.dm_rd_sel = DmRdNone;
        dec.dm_wr_sel = DmWrNone;
        bad_enc       = 1'b0;
        use_rd        = 1'b0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;

        case (opcode)
            OpLui: begin
                dec.imm       = imm_u;
                dec.alu_ctrl  = AluPassB;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WbAlu;
                use_rd        = 1'b1;
            end
            OpAuipc: begin
                dec.imm       = imm_u;
                dec.alu_a_sel = 1'b0;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WbAlu;
                use_rd        = 1'b1;
            end
            OpJal: begin
                dec.imm       = imm_j;
                dec.alu_a_sel = 1'b0;
                dec.do_jump   = 1'b1;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WbPc4;
                use_rd        = 1'b1;
            end
            OpJalr: begin
                dec.imm       = imm_i;
                dec.do_jump   = 1'b1;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WbPc4;
                use_rd        = 1'b1;
                use_rs1       = 1'b1;
                bad_enc       = funct3 != 3'b000;
            end
            OpBranch: begin
                dec.imm       = imm_b;
                dec.alu_a_sel = 1'b0;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                case (funct3)
                    3'b000:  dec.br_type = BrEq;
                    3'b001:  dec.br_type = BrNe;
                    3'b100:  dec.br_type = BrLt;
                    3'b101:  dec.br_type = BrGe;
                    3'b110:  dec.br_type = BrLtu;
                    3'b111:  dec.br_type = BrGeu;
                    default: bad_enc = 1'b1;
                endcase
            end
            OpLoad: begin
                dec.imm       = imm_i;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WbMem;
                use_rd        = 1'b1;
                use_rs1       = 1'b1;
                case (funct3)
                    3'b000:  dec.dm_rd_sel = DmRdLb;
                    3'b100:  dec.dm_rd_sel = DmRdLbu;
                    3'b001:  dec.dm_rd_sel = DmRdLh;
                    3'b101:  dec.dm_rd_sel = DmRdLhu;
                    3'b010:  dec.dm_rd_sel = DmRdLw;
                    default: bad_enc = 1'b1;
                endcase
            end
            OpStore: begin
                dec.imm = imm_s;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  dec.dm_wr_sel = DmWrSb;
                    3'b001:  dec.dm_wr_sel = DmWrSh;
                    3'b010:  dec.dm_wr_sel = DmWrSw;
                    default: bad_enc = 1'b1;
                endcase
            end
            OpImm: begin
                dec.imm       = imm_i;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WbAlu;
                use_rd        = 1'b1;
                use_rs1       = 1'b1;
                case (funct3)
                    3'b000: dec.alu_ctrl = AluAdd;
                    3'b010: dec.alu_ctrl = AluSlt;
                    3'b011: dec.alu_ctrl = AluSltu;
                    3'b100: dec.alu_ctrl = AluXor;
                    3'b110: dec.alu_ctrl = AluOr;
                    3'b111: dec.alu_ctrl = AluAnd;
                    3'b001: begin
                        dec.alu_ctrl = AluSll;
                        bad_enc      = funct7 != Funct7Base;
                    end
                    default: begin
                        if (funct7 == Funct7Base)     dec.alu_ctrl = AluSrl;
                        else if (funct7 == Funct7Alt) dec.alu_ctrl = AluSra;
                        else                          bad_enc = 1'b1;
                    end
                endcase
            end
            OpReg: begin
                dec.alu_b_sel = 1'b0;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WbAlu;
                use_rd        = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                if (funct7 == Funct7Base) begin
                    case (funct3)
                        3'b000:  dec.alu_ctrl = AluAdd;
                        3'b001:  dec.alu_ctrl = AluSll;
                        3'b010:  dec.alu_ctrl = AluSlt;
                        3'b011:  dec.alu_ctrl = AluSltu;
                        3'b100:  dec.alu_ctrl = AluXor;
                        3'b101:  dec.alu_ctrl = AluSrl;
                        3'b110:  dec.alu_ctrl = AluOr;
                        default: dec.alu_ctrl = AluAnd;
                    endcase
                end else if (funct7 == Funct7Alt) begin
                    case (funct3)
                        3'b000:  dec.alu_ctrl = AluSub;
                        3'b101:  dec.alu_ctrl = AluSra;
                        default: bad_enc = 1'b1;
                    endcase
                end else if (EN_M && funct7 == Funct7Mul) begin
                    dec.mdu_op = {1'b1, funct3};
                end else begin
                    bad_enc = 1'b1;
                end
            end
            OpFence:  bad_enc = funct3 != 3'b000;
            OpSystem: begin
                if (inst == InstEbreak)      dec.ebreak = 1'b1;
                else if (inst != InstEcall)  bad_enc = 1'b1;
            end
            default: bad_enc = 1'b1;
        endcase

        // Only fields the format actually reads are range-checked for RV32E.
        illegal = bad_enc | (use_rd & idx_bad(rd)) | (use_rs1 & idx_bad(rs1))
                | (use_rs2 & idx_bad(rs2));

        bundle = dec;
        if (illegal) begin
            bundle.illegal   = 1'b1;
            bundle.rf_wr_en  = 1'b0;
            bundle.rf_wr_sel = WbNone;
            bundle.do_jump   = 1'b0;
            bundle.br_type   = BrNone;
            bundle.dm_rd_sel = DmRdNone;
            bundle.dm_wr_sel = DmWrNone;
            bundle.mdu_op    = 4'b0000;
            bundle.ebreak    = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_idu_stage.sv
// Decode stage: decodes on accept and queues bundles in a small FIFO towards EXU.
module ysyx_idu_stage
    import ysyx_idu_pkg::*;
#(
    parameter int unsigned QDEPTH    = 2,
    parameter bit          EN_M      = 1'b0,
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    ysyx_idu_if.slave                bus,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CntW = $clog2(QDEPTH) + 1;

    idu_bundle_t         dec_bundle;
    idu_bundle_t         mem_q [QDEPTH];
    idu_bundle_t         head;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                push, pop, in_ready, out_valid;

    ysyx_idu_dec #(
        .EN_M      (EN_M),
        .RF_ADDR_W (RF_ADDR_W)
    ) u_dec (
        .inst   (bus.in_inst),
        .pc     (bus.in_pc),
        .bundle (dec_bundle)
    );

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(QDEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // No ready-through: a full queue refuses input even if EXU pops this cycle.
    assign in_ready  = (count_q != CntW'(QDEPTH)) && !flush;
    assign out_valid = count_q != '0;
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: every payload output is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec_bundle;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign count             = count_q;
    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_pc        = head.pc;
    assign bus.out_imm       = head.imm;
    assign bus.out_rs1       = head.rs1[RF_ADDR_W-1:0];
    assign bus.out_rs2       = head.rs2[RF_ADDR_W-1:0];
    assign bus.out_rd        = head.rd[RF_ADDR_W-1:0];
    assign bus.out_rf_wr_en  = head.rf_wr_en;
    assign bus.out_rf_wr_sel = head.rf_wr_sel;
    assign bus.out_do_jump   = head.do_jump;
    assign bus.out_br_type   = head.br_type;
    assign bus.out_alu_a_sel = head.alu_a_sel;
    assign bus.out_alu_b_sel = head.alu_b_sel;
    assign bus.out_alu_ctrl  = head.alu_ctrl;
    assign bus.out_mdu_op    = head.mdu_op;
    assign bus.out_dm_rd_sel = head.dm_rd_sel;
    assign bus.out_dm_wr_sel = head.dm_wr_sel;
    assign bus.out_ebreak    = head.ebreak;
    assign bus.out_illegal   = head.illegal;

endmodule
